// File: rtl/nios_dbg_pkg.sv
// Shared definitions for the Nios debug-slave virtual-JTAG initiator:
// default widths, virtual IR codes and the scan FSM state encoding.
package nios_dbg_pkg;

    localparam int unsigned DEF_DATA_W = 38;
    localparam int unsigned DEF_IR_W   = 2;

    localparam logic [1:0] IR_OCIMEM    = 2'b00;
    localparam logic [1:0] IR_TRACEMEM  = 2'b01;
    localparam logic [1:0] IR_BREAK     = 2'b10;
    localparam logic [1:0] IR_TRACECTRL = 2'b11;

    typedef logic [2:0] state_t;

    localparam state_t StIdle  = 3'd0;
    localparam state_t StUir   = 3'd1;
    localparam state_t StCdr   = 3'd2;
    localparam state_t StShift = 3'd3;
    localparam state_t StUdr   = 3'd4;
    localparam state_t StRti   = 3'd5;
    localparam state_t StResp  = 3'd6;

endpackage

// File: rtl/nios_debug_tck_gen.sv
// Divider producing a registered, glitch-free tck plus single-clk strobes that
// mark the clk edge on which tck rises, falls and the tck period ends.
module nios_debug_tck_gen #(
    parameter int unsigned TCK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en_i,
    input  logic start_i,
    output logic tck_o,
    output logic tck_rise_en_o,
    output logic tck_fall_en_o,
    output logic period_end_o
);

    localparam int unsigned CntW = $clog2(2 * TCK_DIV);
    localparam logic [CntW-1:0] HalfLast = CntW'(TCK_DIV - 1);
    localparam logic [CntW-1:0] PerLast  = CntW'(2 * TCK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            tck_q, tck_d;
    logic            run;

    assign run = en_i && !start_i;

    always_comb begin
        cnt_d = '0;
        if (run) begin
            cnt_d = (cnt_q == PerLast) ? '0 : cnt_q + CntW'(1);
        end
        // tck mirrors the second half of the count, one register stage deep
        tck_d = run && (cnt_d > HalfLast);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            tck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tck_q <= tck_d;
        end
    end

    assign tck_o         = tck_q;
    assign tck_rise_en_o = run && (cnt_q == HalfLast);
    assign period_end_o  = run && (cnt_q == PerLast);
    assign tck_fall_en_o = period_end_o;

endmodule

// File: rtl/nios_debug_jtag_initiator.sv
// Issues one virtual-JTAG IR update plus DR scan per command towards the Nios
// debug slave and returns the captured tdo bits as a response word.
module nios_debug_jtag_initiator
    import nios_dbg_pkg::*;
#(
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned IR_W        = DEF_IR_W,
    parameter int unsigned TCK_DIV     = 2,
    parameter int unsigned RTI_PERIODS = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [IR_W-1:0]   cmd_ir,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [IR_W-1:0]   rsp_ir_out,
    output logic              tck,
    output logic              tdi,
    input  logic              tdo,
    output logic [IR_W-1:0]   ir_in,
    input  logic [IR_W-1:0]   ir_out,
    output logic              vs_uir,
    output logic              vs_cdr,
    output logic              vs_sdr,
    output logic              vs_udr,
    output logic              jtag_state_rti
);

    localparam int unsigned MaxCnt = (DATA_W > RTI_PERIODS) ? DATA_W : RTI_PERIODS;
    localparam int unsigned PhW    = $clog2(MaxCnt + 1);
    localparam logic [PhW-1:0] LastBit = PhW'(DATA_W - 1);
    localparam logic [PhW-1:0] LastRti = PhW'((RTI_PERIODS == 0) ? 0 : RTI_PERIODS - 1);

    state_t            state_q, state_d;
    logic [PhW-1:0]    phase_q, phase_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] cap_q, cap_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [IR_W-1:0]   ir_in_q, ir_in_d;
    logic [IR_W-1:0]   rsp_ir_out_q, rsp_ir_out_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              tdi_q, tdi_d;
    logic              vs_uir_q, vs_cdr_q, vs_sdr_q, vs_udr_q, rti_q;
    logic              accept, tck_en, tck_rise, tck_fall, period_end;

    assign cmd_ready = (state_q == StIdle) && !rsp_valid_q;
    assign accept    = cmd_ready && cmd_valid;
    assign tck_en    = (state_q != StIdle);

    nios_debug_tck_gen #(
        .TCK_DIV (TCK_DIV)
    ) u_tck_gen (
        .clk           (clk),
        .reset_n       (reset_n),
        .en_i          (tck_en),
        .start_i       (accept),
        .tck_o         (tck),
        .tck_rise_en_o (tck_rise),
        .tck_fall_en_o (tck_fall),
        .period_end_o  (period_end)
    );

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        shift_d      = shift_q;
        cap_d        = cap_q;
        ir_in_d      = ir_in_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_ir_out_d = rsp_ir_out_q;

        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StUir;
                    ir_in_d = cmd_ir;
                    shift_d = cmd_data;
                end
            end
            StUir: begin
                if (period_end) begin
                    state_d      = StCdr;
                    rsp_ir_out_d = ir_out;
                end
            end
            StCdr: begin
                if (period_end) begin
                    state_d = StShift;
                    phase_d = '0;
                end
            end
            StShift: begin
                if (tck_rise) begin
                    shift_d            = shift_q >> 1;
                    cap_d              = cap_q >> 1;
                    cap_d[DATA_W-1]    = tdo;
                end
                if (period_end) begin
                    if (phase_q == LastBit) state_d = StUdr;
                    else                    phase_d = phase_q + PhW'(1);
                end
            end
            StUdr: begin
                if (period_end) begin
                    phase_d = '0;
                    state_d = (RTI_PERIODS == 0) ? StResp : StRti;
                end
            end
            StRti: begin
                if (period_end) begin
                    if (phase_q == LastRti) state_d = StResp;
                    else                    phase_d = phase_q + PhW'(1);
                end
            end
            StResp: begin
                state_d     = StIdle;
                rsp_valid_d = 1'b1;
                rsp_data_d  = cap_q;
            end
            default: state_d = StIdle;
        endcase

        // tdi only moves on the tck falling edge so it is stable at each rise
        tdi_d = tdi_q;
        if (state_d != StShift) begin
            tdi_d = 1'b0;
        end else if (tck_fall) begin
            tdi_d = shift_q[0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            phase_q      <= '0;
            shift_q      <= '0;
            cap_q        <= '0;
            ir_in_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_ir_out_q <= '0;
            tdi_q        <= 1'b0;
            vs_uir_q     <= 1'b0;
            vs_cdr_q     <= 1'b0;
            vs_sdr_q     <= 1'b0;
            vs_udr_q     <= 1'b0;
            rti_q        <= 1'b1;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            shift_q      <= shift_d;
            cap_q        <= cap_d;
            ir_in_q      <= ir_in_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_ir_out_q <= rsp_ir_out_d;
            tdi_q        <= tdi_d;
            vs_uir_q     <= (state_d == StUir);
            vs_cdr_q     <= (state_d == StCdr);
            vs_sdr_q     <= (state_d == StShift);
            vs_udr_q     <= (state_d == StUdr);
            rti_q        <= (state_d == StIdle) || (state_d == StRti);
        end
    end

    assign rsp_valid      = rsp_valid_q;
    assign rsp_data       = rsp_data_q;
    assign rsp_ir_out     = rsp_ir_out_q;
    assign ir_in          = ir_in_q;
    assign tdi            = tdi_q;
    assign vs_uir         = vs_uir_q;
    assign vs_cdr         = vs_cdr_q;
    assign vs_sdr         = vs_sdr_q;
    assign vs_udr         = vs_udr_q;
    assign jtag_state_rti = rti_q;

endmodule

// File: doc/nios_debug_jtag_initiator.md
Name: nios_debug_jtag_initiator

Overview:
Clocked-logic initiator for the Nios debug-slave virtual-JTAG interface. It drives the virtual-JTAG signal set (tck, tdi, ir_in, vs_uir/cdr/sdr/udr, jtag_state_rti) to issue one IR-select plus DR-scan per command and captures tdo into a response word. It replaces the sld_virtual_jtag_basic hub in system-level simulation and in on-chip self-test builds, so firmware and benches can drive debug-slave commands without a host cable.

Parameters:
DATA_W, 38, DR scan length in bits (matches the debug-slave sr/jdo width)
IR_W, 2, virtual IR width
TCK_DIV, 2, clk cycles per tck half-period; legal range is TCK_DIV >= 2
RTI_PERIODS, 2, tck periods held in run-test-idle after UDR, before the response

Ports:
clk  in  1  system clock; the only clock
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accept; high only in IDLE with no pending response
cmd_ir  in  IR_W  virtual IR value for the command
cmd_data  in  DATA_W  DR data to shift in, LSB first
rsp_valid  out  1  response available; held until rsp_ready
rsp_ready  in  1  response consumed
rsp_data  out  DATA_W  captured tdo bits; bit0 is the first sampled bit
rsp_ir_out  out  IR_W  ir_out sampled at the end of the UIR phase
tck  out  1  generated test clock (a data signal, not a clock net)
tdi  out  1  serial data to the slave
tdo  in  1  serial data from the slave
ir_in  out  IR_W  virtual IR; holds its value between commands
ir_out  in  IR_W  slave IR status
vs_uir  out  1  update-IR strobe
vs_cdr  out  1  capture-DR state
vs_sdr  out  1  shift-DR state
vs_udr  out  1  update-DR strobe
jtag_state_rti  out  1  run-test-idle indication

Behaviour:
- Reset values: all outputs 0, including ir_in, rsp_data and rsp_ir_out. cmd_ready=1 and jtag_state_rti=1 (IDLE). Reset is asynchronous, takes effect in any state and aborts a scan with no response.
- tck period = 2*TCK_DIV clk cycles: low for the first TCK_DIV cycles, high for the second. A free-running divider counter runs only outside IDLE and restarts at 0 on entry to UIR.
- States: IDLE -> UIR -> CDR -> SHIFT -> UDR -> RTI -> RESP -> IDLE.
  - Each phase lasts whole tck periods. UIR, CDR and UDR last 1 period each, SHIFT lasts DATA_W periods, RTI lasts RTI_PERIODS periods.
- IDLE:
  - cmd_ready = !rsp_valid.
  - On the cmd_valid&&cmd_ready edge, latch cmd_ir into ir_in and cmd_data into the shift register.
- UIR: vs_uir=1 for the whole period, so it survives the slave's two-flop synchroniser. rsp_ir_out <= ir_out on the last clk of the period.
- CDR: vs_cdr=1.
- SHIFT:
  - vs_sdr=1.
  - tdi = shift_reg[0], changing only during the tck-low half.
  - On each clk where tck goes 0->1: rsp capture <= {tdo, capture[DATA_W-1:1]}, and shift_reg shifts right.
  - A bit counter ends the phase after exactly DATA_W rising edges.
- UDR: vs_udr=1 for 1 period, with tdi=0.
- RTI: jtag_state_rti=1 and tck keeps toggling.
- RESP:
  - rsp_valid=1 and rsp_data=capture.
  - Return to IDLE on the same edge; rsp_valid stays high until rsp_ready. rsp_ready with rsp_valid=1 clears rsp_valid next edge.
- Only one of vs_uir, vs_cdr, vs_sdr, vs_udr is high at any time. jtag_state_rti=1 in IDLE and RTI only.
- Latency: rsp_valid rises 2*TCK_DIV*(DATA_W+3+RTI_PERIODS)+1 clk edges after the accept edge (173 at defaults).
- Boundaries:
  - cmd_valid during a scan or while a response is pending is not accepted, and cmd_data is not sampled.
  - rsp_ready without rsp_valid is ignored.
  - DATA_W=1 is legal: a single SHIFT period.
- tck is a registered output and is glitch-free.

Decomposition:
- Shared package nios_dbg_pkg holds:
  - the state enum;
  - IR code constants: IR_OCIMEM=2'b00, IR_TRACEMEM=2'b01, IR_BREAK=2'b10, IR_TRACECTRL=2'b11;
  - default DATA_W/IR_W.
- One sub-module, nios_debug_tck_gen: the divider counter. It outputs tck, tck_rise_en, tck_fall_en and period_end, and is enabled by the FSM.

Test Plan:
- Reset, then a command with ir=2'b10 and data=38'h2A_5555_AAAA -> slave model sees ir_in=2'b10 at vs_uir. tdi bits LSB-first equal the data. Exactly 38 tck rising edges occur under vs_sdr.
- Slave model loads sr=38'h3F_0123_4567 at CDR -> rsp_data=38'h3F_0123_4567 and rsp_ir_out equals the model's ir_out.
- Defaults -> rsp_valid rises exactly 173 clk after the accept edge. vs_uir and vs_udr each stay high exactly 4 clk.
- Hold rsp_ready=0 for 50 cycles with cmd_valid=1 -> cmd_ready stays 0, with no second vs_uir. After rsp_ready=1, rsp_valid drops next edge and the next command is accepted.
- Assert reset_n=0 mid-SHIFT at bit 17 -> all strobes, tck and rsp_valid go 0 immediately. After release: cmd_ready=1, jtag_state_rti=1, no response.
- Set TCK_DIV=3 and DATA_W=1 -> tck high/low phases each 3 clk. Response latency is 6*(1+3+2)+1=37 clk.
